// File: rtl/match_pkg.sv
// Shared types and default constants for the match sequencer.
package match_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_e;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;

  localparam int unsigned DEF_SCORE_W      = 4;
  localparam int unsigned DEF_WIN_SCORE    = 9;
  localparam int unsigned DEF_SERVE_FRAMES = 60;
  localparam int unsigned DEF_POINT_FRAMES = 90;
  localparam int unsigned DEF_FRAME_CNT_W  = 7;

endpackage

// File: rtl/match_sequencer_if.sv
// Key/event inputs and game-flow outputs exchanged with the ball datapath.
interface match_sequencer_if #(
  parameter int unsigned SCORE_W = 4
) ();

  logic               new_frame_i;
  logic               start_i;
  logic               miss_left_i;
  logic               miss_right_i;
  logic               ball_reset_o;
  logic               ball_run_o;
  logic               serve_dir_o;
  logic [SCORE_W-1:0] score_left_o;
  logic [SCORE_W-1:0] score_right_o;
  logic [1:0]         winner_o;
  logic [2:0]         state_o;

  modport slave (
    input  new_frame_i, start_i, miss_left_i, miss_right_i,
    output ball_reset_o, ball_run_o, serve_dir_o,
           score_left_o, score_right_o, winner_o, state_o
  );

  modport master (
    output new_frame_i, start_i, miss_left_i, miss_right_i,
    input  ball_reset_o, ball_run_o, serve_dir_o,
           score_left_o, score_right_o, winner_o, state_o
  );

endinterface

// File: rtl/match_sequencer_frame_timer.sv
// Frame counter shared by the serve and point waits; o_done_c fires on the
// frame that brings the count up to i_target.
module frame_timer #(
  parameter int unsigned FRAME_CNT_W = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   i_clr,
  input  logic                   i_en,
  input  logic                   i_new_frame,
  input  logic [FRAME_CNT_W-1:0] i_target,
  output logic                   o_done_c
);

  logic [FRAME_CNT_W-1:0] r_cnt;
  logic [FRAME_CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = FRAME_CNT_W'(r_cnt + FRAME_CNT_W'(1));
  assign o_done_c  = i_en & i_new_frame & (w_cnt_inc == i_target);

  always_ff @(posedge clk_i) begin
    if (rst_i || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && i_new_frame) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/match_sequencer.sv
// Game-flow controller: sequences idle/serve/play/point/over, owns the scores
// and drives ball re-centre, run enable and serve direction.
module match_sequencer
  import match_pkg::*;
#(
  parameter int unsigned SCORE_W      = DEF_SCORE_W,
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int unsigned POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int unsigned FRAME_CNT_W  = DEF_FRAME_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  match_sequencer_if.slave  bus
);

  state_e               r_state, w_state;
  logic [SCORE_W-1:0]   r_score_l, w_score_l;
  logic [SCORE_W-1:0]   r_score_r, w_score_r;
  logic [1:0]           r_winner, w_winner;
  logic                 r_dir, w_dir;
  logic                 r_ball_reset, w_ball_reset;
  logic                 r_ball_run, w_ball_run;
  logic                 r_start_q;
  logic                 w_start_edge;
  logic                 w_tmr_clr, w_tmr_en, w_tmr_done;
  logic [FRAME_CNT_W-1:0] w_tmr_target;

  assign w_start_edge = bus.start_i & ~r_start_q;

  frame_timer #(.FRAME_CNT_W(FRAME_CNT_W)) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_clr       (w_tmr_clr),
    .i_en        (w_tmr_en),
    .i_new_frame (bus.new_frame_i),
    .i_target    (w_tmr_target),
    .o_done_c    (w_tmr_done)
  );

  // Start key copy resets high so a key held through reset is not an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_winner     <= WINNER_NONE;
      r_dir        <= 1'b0;
      r_ball_reset <= 1'b0;
      r_ball_run   <= 1'b0;
      r_start_q    <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_score_l    <= w_score_l;
      r_score_r    <= w_score_r;
      r_winner     <= w_winner;
      r_dir        <= w_dir;
      r_ball_reset <= w_ball_reset;
      r_ball_run   <= w_ball_run;
      r_start_q    <= bus.start_i;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_score_l    = r_score_l;
    w_score_r    = r_score_r;
    w_winner     = r_winner;
    w_dir        = r_dir;
    w_ball_reset = 1'b0;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = 1'b0;
    w_tmr_target = FRAME_CNT_W'(SERVE_FRAMES);

    case (r_state)
      IDLE, OVER: begin
        if (w_start_edge) begin
          w_state      = SERVE;
          w_score_l    = '0;
          w_score_r    = '0;
          w_winner     = WINNER_NONE;
          w_ball_reset = 1'b1;
          w_tmr_clr    = 1'b1;
        end
      end
      SERVE: begin
        w_tmr_en = 1'b1;
        if (w_tmr_done) w_state = PLAY;
      end
      PLAY: begin
        // A simultaneous double miss is a void rally: pause without scoring.
        if (bus.miss_left_i || bus.miss_right_i) begin
          w_state   = POINT;
          w_tmr_clr = 1'b1;
          if (bus.miss_left_i && !bus.miss_right_i) begin
            w_score_r = SCORE_W'(r_score_r + SCORE_W'(1));
            w_dir     = 1'b0;
          end else if (bus.miss_right_i && !bus.miss_left_i) begin
            w_score_l = SCORE_W'(r_score_l + SCORE_W'(1));
            w_dir     = 1'b1;
          end
        end
      end
      POINT: begin
        w_tmr_target = FRAME_CNT_W'(POINT_FRAMES);
        if (r_score_l == SCORE_W'(WIN_SCORE)) begin
          w_winner = WINNER_LEFT;
          w_state  = OVER;
        end else if (r_score_r == SCORE_W'(WIN_SCORE)) begin
          w_winner = WINNER_RIGHT;
          w_state  = OVER;
        end else begin
          w_tmr_en = 1'b1;
          if (w_tmr_done) begin
            w_state      = SERVE;
            w_ball_reset = 1'b1;
            w_tmr_clr    = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    w_ball_run = (w_state == PLAY);
  end

  assign bus.state_o       = r_state;
  assign bus.score_left_o  = r_score_l;
  assign bus.score_right_o = r_score_r;
  assign bus.winner_o      = r_winner;
  assign bus.serve_dir_o   = r_dir;
  assign bus.ball_reset_o  = r_ball_reset;
  assign bus.ball_run_o    = r_ball_run;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with short serve/point waits and WIN_SCORE=2.
module tb_match_sequencer;

  localparam int unsigned SCORE_W = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   br_seen  = 0;

  match_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

  match_sequencer #(
    .SCORE_W      (SCORE_W),
    .WIN_SCORE    (2),
    .SERVE_FRAMES (3),
    .POINT_FRAMES (2),
    .FRAME_CNT_W  (7)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and tally any ball_reset pulse seen there.
  task automatic tick();
    @(negedge clk_i);
    if (bus.ball_reset_o) br_seen++;
  endtask

  task automatic frame();
    bus.new_frame_i = 1'b1;
    tick();
    bus.new_frame_i = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_miss(input logic l, input logic r, input logic nf);
    bus.miss_left_i  = l;
    bus.miss_right_i = r;
    bus.new_frame_i  = nf;
    tick();
    bus.miss_left_i  = 1'b0;
    bus.miss_right_i = 1'b0;
    bus.new_frame_i  = 1'b0;
  endtask

  task automatic press_start();
    bus.start_i = 1'b0;
    tick();
    bus.start_i = 1'b1;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(bus.state_o), 32'd0);
    check({tag, "_run"},   32'(bus.ball_run_o), 32'd0);
    check({tag, "_brst"},  32'(bus.ball_reset_o), 32'd0);
    check({tag, "_dir"},   32'(bus.serve_dir_o), 32'd0);
    check({tag, "_scl"},   32'(bus.score_left_o), 32'd0);
    check({tag, "_scr"},   32'(bus.score_right_o), 32'd0);
    check({tag, "_win"},   32'(bus.winner_o), 32'd0);
  endtask

  initial begin
    int br0;
    bus.new_frame_i  = 1'b0;
    bus.start_i      = 1'b1;
    bus.miss_left_i  = 1'b0;
    bus.miss_right_i = 1'b0;
    rst_i = 1'b1;
    tick(); tick(); tick();
    rst_i = 1'b0;
    check_reset_vals("rst");

    // Key held through reset must not start a match.
    br_seen = 0;
    frames(10);
    check("held_state", 32'(bus.state_o), 32'd0);
    check("held_brst_cnt", 32'(br_seen), 32'd0);

    press_start();
    check("start_state", 32'(bus.state_o), 32'd1);
    check("start_brst", 32'(bus.ball_reset_o), 32'd1);
    tick();
    check("start_brst_once", 32'(br_seen), 32'd1);

    frames(2);
    check("serve2_state", 32'(bus.state_o), 32'd1);
    check("serve2_run", 32'(bus.ball_run_o), 32'd0);
    pulse_miss(1'b1, 1'b0, 1'b0);
    check("serve_miss_ignored_scr", 32'(bus.score_right_o), 32'd0);
    check("serve_miss_ignored_st", 32'(bus.state_o), 32'd1);
    frame();
    check("serve3_state", 32'(bus.state_o), 32'd2);
    check("serve3_run", 32'(bus.ball_run_o), 32'd1);

    pulse_miss(1'b0, 1'b1, 1'b0);
    check("mr_scl", 32'(bus.score_left_o), 32'd1);
    check("mr_dir", 32'(bus.serve_dir_o), 32'd1);
    check("mr_state", 32'(bus.state_o), 32'd3);
    check("mr_run", 32'(bus.ball_run_o), 32'd0);
    frame();
    check("point1_state", 32'(bus.state_o), 32'd3);
    br0 = br_seen;
    bus.new_frame_i = 1'b1;
    tick();
    bus.new_frame_i = 1'b0;
    check("point2_brst", 32'(bus.ball_reset_o), 32'd1);
    check("point2_state", 32'(bus.state_o), 32'd1);
    tick();
    check("point2_brst_once", 32'(br_seen - br0), 32'd1);
    frames(3);
    check("serve_again_state", 32'(bus.state_o), 32'd2);

    pulse_miss(1'b1, 1'b1, 1'b0);
    check("both_scl", 32'(bus.score_left_o), 32'd1);
    check("both_scr", 32'(bus.score_right_o), 32'd0);
    check("both_dir", 32'(bus.serve_dir_o), 32'd1);
    check("both_state", 32'(bus.state_o), 32'd3);
    frames(2);
    check("both_serve", 32'(bus.state_o), 32'd1);
    frames(3);
    check("both_play", 32'(bus.state_o), 32'd2);

    pulse_miss(1'b0, 1'b1, 1'b0);
    check("win_scl", 32'(bus.score_left_o), 32'd2);
    check("win_point", 32'(bus.state_o), 32'd3);
    tick();
    check("win_state", 32'(bus.state_o), 32'd4);
    check("win_winner", 32'(bus.winner_o), 32'd1);
    pulse_miss(1'b1, 1'b0, 1'b0);
    frames(3);
    check("over_scr", 32'(bus.score_right_o), 32'd0);
    check("over_scl", 32'(bus.score_left_o), 32'd2);
    check("over_state", 32'(bus.state_o), 32'd4);
    check("over_run", 32'(bus.ball_run_o), 32'd0);

    press_start();
    check("new_state", 32'(bus.state_o), 32'd1);
    check("new_scl", 32'(bus.score_left_o), 32'd0);
    check("new_win", 32'(bus.winner_o), 32'd0);
    check("new_brst", 32'(bus.ball_reset_o), 32'd1);

    // Reset mid-serve; the counter must not carry over into the next serve.
    frame();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_vals("midrst");
    frames(2);
    check("midrst_held", 32'(bus.state_o), 32'd0);
    press_start();
    frames(2);
    check("cnt_cleared_state", 32'(bus.state_o), 32'd1);
    frame();
    check("cnt_cleared_play", 32'(bus.state_o), 32'd2);

    // Miss coincident with a frame pulse still scores.
    pulse_miss(1'b1, 1'b0, 1'b1);
    check("ml_scr", 32'(bus.score_right_o), 32'd1);
    check("ml_dir", 32'(bus.serve_dir_o), 32'd0);
    check("ml_state", 32'(bus.state_o), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
